// File: rtl/sb_drain_dcache.sv
// sb_drain_dcache
// Data-cache write responder for the store-buffer drain interface. Each
// CacheWrite request carries one store (word or byte) that is committed into
// a direct-mapped, write-back, write-allocate cache. A one-cycle CacheReady
// pulse acknowledges the commit. Misses go through a line-wide memory
// handshake: dirty-victim writeback first, then refill.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   CacheWrite                drain request, held until CacheReady
//   Address_in                store byte address
//   Data_in                   store data
//   ByteAddress_in            1 = byte store of Data_in[7:0], 0 = word store
//   CacheReady                one-cycle commit acknowledge (registered)
//   Busy                      controller is not in IDLE
//   mem_req/mem_we            memory request; 1 = line write, 0 = line read
//   mem_addr/mem_wdata        line-aligned address; victim line data
//   mem_rdata/mem_ready       refill data; memory completes the request
//   HitCount/MissCount        16-bit saturating counters (optional)
//
// Optional feature: define DCACHE_PERF_CNT_EN to add the HitCount and
// MissCount outputs and their counters.

module sb_drain_dcache #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int NUM_LINES  = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    CacheWrite,
    input  logic [ADDR_W-1:0]       Address_in,
    input  logic [DATA_W-1:0]       Data_in,
    input  logic                    ByteAddress_in,
    output logic                    CacheReady,
    output logic                    Busy,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LINE_BYTES*8-1:0] mem_wdata,
    input  logic [LINE_BYTES*8-1:0] mem_rdata,
`ifdef DCACHE_PERF_CNT_EN
    output logic [15:0]             HitCount,
    output logic [15:0]             MissCount,
`endif
    input  logic                    mem_ready
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LANE_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

    state_t                 state;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      data_q;
    logic                   byte_q;
    logic [NUM_LINES-1:0]   valid;
    logic [NUM_LINES-1:0]   dirty;
    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]      data_mem [NUM_LINES];

    logic [IDX_W-1:0]       idx_in, idx_q, arr_idx;
    logic [TAG_W-1:0]       tag_in, tag_q, arr_tag;
    logic [LINE_W-1:0]      arr_line;
    logic                   hit, accept, arr_we;

    // Overlay one store onto a line: a word store replaces the selected word,
    // a byte store replaces only lane off[LANE_W-1:0] of that word.
    function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] line,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [DATA_W-1:0] data,
                                                input logic              byte_st);
        logic [LINE_W-1:0] r;
        int                base;
        r    = line;
        base = int'(off[OFF_W-1:LANE_W]) * DATA_W;
        if (byte_st)
            r[base + int'(off[LANE_W-1:0]) * 8 +: 8] = data[7:0];
        else
            r[base +: DATA_W] = data;
        return r;
    endfunction

    assign idx_in = Address_in[OFF_W +: IDX_W];
    assign tag_in = Address_in[ADDR_W-1 -: TAG_W];
    assign idx_q  = addr_q[OFF_W +: IDX_W];
    assign tag_q  = addr_q[ADDR_W-1 -: TAG_W];
    assign accept = (state == IDLE) && CacheWrite;
    assign hit    = valid[idx_in] && (tag_mem[idx_in] == tag_in);
    assign Busy   = (state != IDLE);

    // The line array has two writers: a hit merges the live request into the
    // resident line, a completed refill merges the latched store into mem_rdata.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        arr_we   = 1'b0;
        arr_idx  = idx_q;
        arr_tag  = tag_q;
        arr_line = mem_rdata;
        if (accept && hit) begin
            arr_we   = 1'b1;
            arr_idx  = idx_in;
            arr_tag  = tag_in;
            arr_line = merge(data_mem[idx_in], Address_in[OFF_W-1:0], Data_in, ByteAddress_in);
        end else if (state == REFILL && mem_ready) begin
            arr_we   = 1'b1;
            arr_line = merge(mem_rdata, addr_q[OFF_W-1:0], data_q, byte_q);
        end
    end

    // NOTE: tag and data arrays are deliberately left out of reset; the
    // cleared valid bits make their contents unobservable after reset.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_mem[arr_idx] <= arr_line;
            tag_mem[arr_idx]  <= arr_tag;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            byte_q     <= 1'b0;
            CacheReady <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef DCACHE_PERF_CNT_EN
            HitCount   <= '0;
            MissCount  <= '0;
`endif
        end else begin
            CacheReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (CacheWrite) begin
                        addr_q <= Address_in;
                        data_q <= Data_in;
                        byte_q <= ByteAddress_in;
                        if (hit) begin
                            dirty[idx_in] <= 1'b1;
                            CacheReady    <= 1'b1;
                            state         <= DONE;
                        end else if (valid[idx_in] && dirty[idx_in]) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_mem[idx_in], idx_in, {OFF_W{1'b0}}};
                            mem_wdata <= data_mem[idx_in];
                            state     <= WRITEBACK;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag_in, idx_in, {OFF_W{1'b0}}};
                            state    <= REFILL;
                        end
`ifdef DCACHE_PERF_CNT_EN
                        if (hit && HitCount != 16'hFFFF)
                            HitCount <= HitCount + 16'd1;
                        if (!hit && MissCount != 16'hFFFF)
                            MissCount <= MissCount + 16'd1;
`endif
                    end
                end
                WRITEBACK: begin
                    // mem_req stays high straight into the refill read.
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        mem_addr <= {tag_q, idx_q, {OFF_W{1'b0}}};
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        mem_req      <= 1'b0;
                        valid[idx_q] <= 1'b1;
                        dirty[idx_q] <= 1'b1;
                        CacheReady   <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // CacheWrite is still high here; it must not start a new store.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
